// File: rtl/spi_quad_controller.sv
// Quad-SPI initiator: turns single-word register read/write requests into framed
// 4-bit-wide SPI transactions (mode 0, MSB nibble first) and returns read data.
module spi_quad_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned AWIDTH   = 7,
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              busy,
  output logic              SCK,
  output logic              CS_N,
  output logic [3:0]        COPI,
  input  logic [3:0]        CIPO
);

  localparam int unsigned CmdNib  = (AWIDTH + 1) / 4;
  localparam int unsigned DataNib = DWIDTH / 4;
  localparam int unsigned TxW     = 1 + AWIDTH + DWIDTH;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned NibMax  = (DataNib > TURN_CYC) ? DataNib : TURN_CYC;
  localparam int unsigned CntW    = $clog2(NibMax + 2);
  localparam int unsigned TurnM1  = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  localparam logic [DivW-1:0] DivLoad  = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CmdLoad  = CntW'(CmdNib - 1);
  localparam logic [CntW-1:0] TurnLoad = CntW'(TurnM1);
  localparam logic [CntW-1:0] DataLoad = CntW'(DataNib - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StCmd,
    StTurn,
    StData,
    StCsHold,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic [TxW-1:0]    tx_q, tx_d;
  logic [DWIDTH-1:0] rx_q, rx_d;
  logic              we_q, we_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tick;

  // Half-period tick; the divider reloads on every tick and on every state entry.
  assign tick = (div_q == '0);

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      cnt_q       <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Frame sequencing: SCK toggles on ticks in CMD/TURN/DATA; CIPO is captured on the
  // rising tick, the next COPI nibble is shifted out on the falling tick.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    if (state_q != StIdle) begin
      div_d = tick ? DivLoad : div_q - DivW'(1);
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StCsSetup;
          div_d   = DivLoad;
          cs_n_d  = 1'b0;
          we_d    = req_we;
          // Reads shift zeros after the command, so COPI stays 0 for the rest of the frame.
          tx_d    = {req_we, req_addr, req_wdata & {DWIDTH{req_we}}};
        end
      end
      StCsSetup: begin
        if (tick) begin
          state_d = StCmd;
          cnt_d   = CmdLoad;
        end
      end
      StCmd, StTurn, StData: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (!sck_q) begin
            if (state_q == StData && !we_q) begin
              rx_d = {rx_q[DWIDTH-5:0], CIPO};
            end
          end else begin
            tx_d = {tx_q[TxW-5:0], 4'h0};
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CntW'(1);
            end else begin
              case (state_q)
                StCmd: begin
                  if (we_q || TURN_CYC == 0) begin
                    state_d = StData;
                    cnt_d   = DataLoad;
                  end else begin
                    state_d = StTurn;
                    cnt_d   = TurnLoad;
                  end
                end
                StTurn: begin
                  state_d = StData;
                  cnt_d   = DataLoad;
                end
                default: state_d = StCsHold;
              endcase
            end
          end
        end
      end
      StCsHold: begin
        if (tick) begin
          state_d     = StGap;
          cs_n_d      = 1'b1;
          cnt_d       = CntW'(1);
          rsp_valid_d = 1'b1;
          if (!we_q) begin
            rdata_d = rx_q;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign SCK       = sck_q;
  assign CS_N      = cs_n_q;
  assign COPI      = tx_q[TxW-1 -: 4];

endmodule

// File: tb/tb_spi_quad_controller.sv
// Directed bench for spi_quad_controller: two instances (CLK_DIV=2 and CLK_DIV=1), each
// attached to a behavioural quad-SPI peripheral with a 128-entry register file.
module tb_spi_quad_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [6:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        busy      [2];
  logic        sck       [2];
  logic        cs_n      [2];
  logic [3:0]  copi      [2];
  logic [3:0]  cipo      [2];

  // Peripheral model and frame monitors
  logic [15:0] regfile   [2][128];
  logic [3:0]  nib_log   [2][16];
  logic [7:0]  cmd       [2];
  logic [15:0] rd_sr     [2];
  logic [15:0] wr_sr     [2];
  logic        sck_prev  [2];
  logic        cs_prev   [2];
  int          rise_n    [2];
  int          cs_low    [2];
  int          sck_edges [2];
  int          hi_cnt    [2];
  int          gap_last  [2];
  int          rsp_cnt   [2];
  bit          init_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_quad_controller #(.CLK_DIV(2), .AWIDTH(7), .DWIDTH(16), .TURN_CYC(2)) u_dut_div2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .SCK(sck[0]), .CS_N(cs_n[0]), .COPI(copi[0]), .CIPO(cipo[0])
  );

  spi_quad_controller #(.CLK_DIV(1), .AWIDTH(7), .DWIDTH(16), .TURN_CYC(2)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .SCK(sck[1]), .CS_N(cs_n[1]), .COPI(copi[1]), .CIPO(cipo[1])
  );

  assign cipo[0] = rd_sr[0][15:12];
  assign cipo[1] = rd_sr[1][15:12];

  // Mode-0 peripheral: acts one clk after each SCK rise it sees; rises 0-1 are the
  // command, rises 2-3 the read turnaround, rises 4-7 read data (writes use rises 2-5).
  always @(posedge clk) begin
    if (!init_done) begin
      init_done <= 1'b1;
      for (int g = 0; g < 2; g++) begin
        for (int a = 0; a < 128; a++) regfile[g][a] <= 16'(a * 3);
        rd_sr[g] <= '0;
      end
      regfile[0][5]     <= 16'hA5C3;
      regfile[1][7'h33] <= 16'hFFFF;
    end else begin
      for (int g = 0; g < 2; g++) begin
        sck_prev[g] <= sck[g];
        cs_prev[g]  <= cs_n[g];
        if (rsp_valid[g] === 1'b1) rsp_cnt[g] <= rsp_cnt[g] + 1;
        if (cs_n[g] !== 1'b0) begin
          hi_cnt[g] <= hi_cnt[g] + 1;
        end else begin
          hi_cnt[g] <= 0;
          if (cs_prev[g] === 1'b1) begin
            gap_last[g]  <= hi_cnt[g];
            cs_low[g]    <= 1;
            sck_edges[g] <= 0;
            rise_n[g]    <= 0;
          end else begin
            cs_low[g] <= cs_low[g] + 1;
            if (sck[g] !== sck_prev[g]) sck_edges[g] <= sck_edges[g] + 1;
            if (sck[g] === 1'b1 && sck_prev[g] === 1'b0) begin
              if (rise_n[g] < 16) nib_log[g][rise_n[g]] <= copi[g];
              rise_n[g] <= rise_n[g] + 1;
              if (rise_n[g] == 0) begin
                cmd[g][7:4] <= copi[g];
              end else if (rise_n[g] == 1) begin
                cmd[g][3:0] <= copi[g];
                if (!cmd[g][7]) rd_sr[g] <= regfile[g][{cmd[g][6:4], copi[g]}];
              end else if (cmd[g][7]) begin
                if (rise_n[g] <= 5) wr_sr[g] <= {wr_sr[g][11:0], copi[g]};
                if (rise_n[g] == 5) regfile[g][cmd[g][6:0]] <= {wr_sr[g][11:0], copi[g]};
              end else if (rise_n[g] >= 4) begin
                rd_sr[g] <= {rd_sr[g][11:0], 4'h0};
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] packed_log(input int g, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < 8; i++) v = {v[27:0], nib_log[g][i]};
    return v;
  endfunction

  // One complete transaction: wait for ready, present one request, wait for the response
  // pulse, then wait until the controller is idle again.
  task automatic do_req(input int g, input logic we, input logic [6:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata);
    bit seen;
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_we[g]    = we;
    req_addr[g]  = addr;
    req_wdata[g] = wdata;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (req_ready[g] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("accept_wait", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    seen  = 1'b0;
    rdata = '0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (rsp_valid[g] === 1'b1) begin
        seen  = 1'b1;
        rdata = rsp_rdata[g];
      end else begin
        @(negedge clk);
      end
    end
    check("rsp_wait", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (req_ready[g] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("idle_wait", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int rc;
    bit seen;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_we[g]    = 1'b0;
      req_addr[g]  = '0;
      req_wdata[g] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck",       32'(sck[0]),       32'd0);
    check("rst_cs_n",      32'(cs_n[0]),      32'd1);
    check("rst_copi",      32'(copi[0]),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    check("rst_ready",     32'(req_ready[0]), 32'd1);
    check("rst_busy",      32'(busy[0]),      32'd0);
    check("rst_cs_n_div1", 32'(cs_n[1]),      32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x03FF to 0x1B: command {1,0x1B} = 0x9B
    rc = rsp_cnt[0];
    do_req(0, 1'b1, 7'h1B, 16'h03FF, rd);
    check("wr_nibbles",  packed_log(0, rise_n[0]), 32'h009B03FF);
    check("wr_rises",    32'(rise_n[0]),            32'd6);
    check("wr_cs_low",   32'(cs_low[0]),            32'd28);
    check("wr_sck_edge", 32'(sck_edges[0]),         32'd12);
    check("wr_rsp_cnt",  32'(rsp_cnt[0] - rc),      32'd1);
    check("wr_regfile",  32'(regfile[0][7'h1B]),    32'h03FF);

    // Read 0x05 (peripheral holds 0xA5C3)
    rc = rsp_cnt[0];
    do_req(0, 1'b0, 7'h05, 16'hFFFF, rd);
    check("rd_data",     32'(rd),                   32'hA5C3);
    check("rd_hold",     32'(rsp_rdata[0]),         32'hA5C3);
    check("rd_nibbles",  packed_log(0, rise_n[0]),  32'h05000000);
    check("rd_cs_low",   32'(cs_low[0]),            32'd36);
    check("rd_sck_edge", 32'(sck_edges[0]),         32'd16);
    check("rd_rsp_cnt",  32'(rsp_cnt[0] - rc),      32'd1);

    // Back-to-back writes with req_valid held high
    rc = rsp_cnt[0];
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 7'h20;
    req_wdata[0] = 16'h1111;
    check("b2b_ready0", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_busy", 32'(busy[0]), 32'd1);
    req_addr[0]  = 7'h21;
    req_wdata[0] = 16'h2222;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (req_ready[0] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_wait1", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (req_ready[0] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_wait2", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check("b2b_rsp_cnt", 32'(rsp_cnt[0] - rc),   32'd2);
    // 2D GAP cycles plus the IDLE cycle in which the held request is accepted
    check("b2b_gap",     32'(gap_last[0]),       32'd5);
    check("b2b_reg20",   32'(regfile[0][7'h20]), 32'h1111);
    check("b2b_reg21",   32'(regfile[0][7'h21]), 32'h2222);

    // Loop-back through the peripheral register file
    do_req(0, 1'b1, 7'h10, 16'h1234, rd);
    check("loop_reg", 32'(regfile[0][7'h10]), 32'h1234);
    do_req(0, 1'b0, 7'h10, 16'h0000, rd);
    check("loop_rd",  32'(rd),                32'h1234);

    // CLK_DIV=1: read 0xFFFF, then a write leaves rsp_rdata untouched
    do_req(1, 1'b0, 7'h33, 16'h0000, rd);
    check("d1_rd_data",  32'(rd),            32'hFFFF);
    check("d1_rd_cs",    32'(cs_low[1]),     32'd18);
    check("d1_rd_edges", 32'(sck_edges[1]),  32'd16);
    do_req(1, 1'b1, 7'h34, 16'h0000, rd);
    check("d1_wr_hold",  32'(rsp_rdata[1]),  32'hFFFF);
    check("d1_wr_cs",    32'(cs_low[1]),     32'd14);
    check("d1_wr_edges", 32'(sck_edges[1]),  32'd12);
    check("d1_wr_reg",   32'(regfile[1][7'h34]), 32'h0000);

    // Reset during the third data nibble of a read
    rc = rsp_cnt[0];
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 7'h05;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (rise_n[0] >= 7) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort_wait", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n",  32'(cs_n[0]),      32'd1);
    check("abort_sck",   32'(sck[0]),       32'd0);
    check("abort_copi",  32'(copi[0]),      32'd0);
    check("abort_rdata", 32'(rsp_rdata[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_cnt[0] - rc), 32'd0);
    do_req(0, 1'b0, 7'h05, 16'h0000, rd);
    check("abort_after", 32'(rd),         32'hA5C3);
    check("abort_cs",    32'(cs_low[0]),  32'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
